// File: rtl/vga_tile_pkg.sv
// rtl/vga_tile_pkg.sv - tile grid geometry, tile codes and writer state encoding
package vga_tile_pkg;

    localparam int TILES_X   = 32;
    localparam int TILES_Y   = 24;
    localparam int TILE_PX   = 20;
    localparam int NUM_TILES = TILES_X * TILES_Y;

    localparam logic [4:0] MAX_Y     = 5'(TILES_Y - 1);
    localparam logic [9:0] LAST_TILE = 10'(NUM_TILES - 1);

    typedef enum logic [2:0] {
        TILE_BLACK  = 3'd0,
        TILE_BLUE   = 3'd1,
        TILE_GREEN  = 3'd2,
        TILE_CYAN   = 3'd3,
        TILE_RED    = 3'd4,
        TILE_PURPLE = 3'd5,
        TILE_YELLOW = 3'd6,
        TILE_WHITE  = 3'd7
    } tile_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } writer_state_e;

    // Row-major tile index: 32 columns per row makes y*32+x a plain concatenation.
    function automatic logic [9:0] tile_addr(input logic [4:0] x, input logic [4:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tile_sweep_counter.sv
// rtl/tile_sweep_counter.sv - full-grid sweep address counter, wraps after the last tile
module tile_sweep_counter
    import vga_tile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [9:0] count,
    output logic       tc
);

    assign tc = (count == LAST_TILE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 10'd1;
        end
    end

endmodule

// File: rtl/tile_writer.sv
// rtl/tile_writer.sv - single-tile writes and full-grid clear into tile RAM
// Optional: TILE_WRITER_VBLANK_ONLY_EN restricts RAM writes to vblank cycles.
module tile_writer
    import vga_tile_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_x,
    input  logic [4:0]        req_y,
    input  logic [CODE_W-1:0] req_code,
    input  logic              clear_start,
    input  logic [CODE_W-1:0] clear_code,
    input  logic              vblank,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [CODE_W-1:0] wdata,
    output logic              busy,
    output logic              clear_done,
    output logic              err_oob
);

    writer_state_e     state, state_next;
    logic [ADDR_W-1:0] wr_addr;
    logic [CODE_W-1:0] wr_data;
    logic              go;
    logic              accept;
    logic              accept_ok;
    logic              clear_go;
    logic              sweep_en;
    logic [9:0]        sweep_count;
    logic              sweep_tc;

`ifdef TILE_WRITER_VBLANK_ONLY_EN
    assign go = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign go = 1'b1;
`endif

    assign req_ready = (state == ST_IDLE) & ~clear_start;
    assign accept    = req_valid & req_ready;
    assign accept_ok = accept & (req_y <= MAX_Y);
    assign clear_go  = (state == ST_IDLE) & clear_start;

    tile_sweep_counter u_sweep (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_go),
        .en    (sweep_en),
        .count (sweep_count),
        .tc    (sweep_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (clear_go) begin
                    state_next = ST_CLEAR;
                end else if (accept_ok) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (go) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (go && sweep_tc) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // During a sweep the live counter drives the bus; otherwise the last address is held.
    always_comb begin
        we       = go & ((state == ST_WRITE) | (state == ST_CLEAR));
        sweep_en = go & (state == ST_CLEAR);
        busy     = (state != ST_IDLE);
        waddr    = sweep_en ? ADDR_W'(sweep_count) : wr_addr;
        wdata    = wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr    <= '0;
            wr_data    <= '0;
            err_oob    <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            err_oob    <= accept & (req_y > MAX_Y);
            clear_done <= sweep_en & sweep_tc;
            if (clear_go) begin
                wr_data <= clear_code;
            end else if (accept_ok) begin
                wr_addr <= ADDR_W'(tile_addr(req_x, req_y));
                wr_data <= req_code;
            end
            if (sweep_en) begin
                wr_addr <= ADDR_W'(sweep_count);
            end
        end
    end

endmodule

// File: tb/tb_tile_writer.sv
// tb/tb_tile_writer.sv - randomized scoreboard bench for tile_writer
module tb_tile_writer;

    localparam int CODE_W = 8;
    localparam int ADDR_W = 10;
`ifdef TILE_WRITER_VBLANK_ONLY_EN
    localparam int TMO_REQ   = 400;
    localparam int TMO_CLEAR = 5000;
`else
    localparam int TMO_REQ   = 20;
    localparam int TMO_CLEAR = 1000;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [4:0]        req_x = '0;
    logic [4:0]        req_y = '0;
    logic [CODE_W-1:0] req_code = '0;
    logic              clear_start = 1'b0;
    logic [CODE_W-1:0] clear_code = '0;
    logic              vblank = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [CODE_W-1:0] wdata;
    logic              busy;
    logic              clear_done;
    logic              err_oob;

    typedef struct packed {
        logic [9:0]        addr;
        logic [CODE_W-1:0] data;
    } wr_t;

    wr_t  exp_wr[$];
    int   n_exp_err  = 0;
    int   n_exp_done = 0;
    int   n_checks   = 0;
    int   n_pass     = 0;
    logic prev_last  = 1'b0;

    tile_writer #(.CODE_W(CODE_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_code    (req_code),
        .clear_start (clear_start),
        .clear_code  (clear_code),
        .vblank      (vblank),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .busy        (busy),
        .clear_done  (clear_done),
        .err_oob     (err_oob)
    );

    always #5 clk = ~clk;

`ifdef TILE_WRITER_VBLANK_ONLY_EN
    int vb_cnt = 0;
    always @(posedge clk) begin
        if (vb_cnt == 99) begin
            vb_cnt <= 0;
            vblank <= ~vblank;
        end else begin
            vb_cnt <= vb_cnt + 1;
        end
    end
`else
    always @(posedge clk) vblank <= 1'($urandom_range(0, 1));
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard monitor: every observed write, error and done pulse must match the model.
    always @(negedge clk) begin
        if (!reset) begin
            prev_last = 1'b0;
        end else begin
            if (we) begin
                check("write_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write_addr", 32'(waddr), 32'(e.addr));
                    check("write_data", 32'(wdata), 32'(e.data));
                end
`ifdef TILE_WRITER_VBLANK_ONLY_EN
                check("write_in_vblank", 32'(vblank), 1);
`endif
            end
            if (err_oob) begin
                check("err_expected", 32'(n_exp_err > 0), 1);
                if (n_exp_err > 0) n_exp_err--;
            end
            if (clear_done) begin
                check("done_expected", 32'(n_exp_done > 0), 1);
                check("done_after_last", 32'(prev_last), 1);
                if (n_exp_done > 0) n_exp_done--;
            end
            prev_last = we && (waddr == 10'd767);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < TMO_CLEAR; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic do_req(input logic [4:0] x, input logic [4:0] y, input logic [CODE_W-1:0] code);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_x = x; req_y = y; req_code = code;
        for (int i = 0; i < TMO_REQ && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                if (y <= 5'd23) exp_wr.push_back('{addr: 10'(int'(y) * 32 + int'(x)), data: code});
                else n_exp_err++;
            end
        end
        if (ok) @(posedge clk);
        #1 req_valid = 1'b0;
        check("req_accepted", 32'(ok), 1);
    endtask

    task automatic do_clear(input logic [CODE_W-1:0] code, input bit wait_done);
        wait_idle();
        @(posedge clk); #1;
        clear_code  = code;
        clear_start = 1'b1;
        req_valid   = 1'b1;
        req_x       = 5'($urandom_range(0, 31));
        req_y       = 5'($urandom_range(0, 23));
        req_code    = CODE_W'($urandom_range(0, 7));
        @(negedge clk);
        check("ready_low_on_clear", 32'(req_ready), 0);
        for (int a = 0; a < 768; a++) exp_wr.push_back('{addr: 10'(a), data: code});
        n_exp_done++;
        @(posedge clk); #1;
        clear_start = 1'b0;
        req_valid   = 1'b0;
        clear_code  = ~code;
        if (wait_done) begin
`ifdef TILE_WRITER_VBLANK_ONLY_EN
            wait_idle();
`else
            for (int i = 0; i < 768; i++) begin
                @(negedge clk);
                check("clear_we_each_cycle", 32'(we), 1);
            end
            @(negedge clk);
            check("clear_done_timing", 32'(clear_done), 1);
            check("clear_idle_after", 32'(busy), 0);
`endif
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(we), 0);
        check({tag, "_waddr"}, 32'(waddr), 0);
        check({tag, "_wdata"}, 32'(wdata), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_clear_done"}, 32'(clear_done), 0);
        check({tag, "_err_oob"}, 32'(err_oob), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic found;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 1);

        // Single legal write: tile (5,3) -> address 101
        do_req(5'd5, 5'd3, 8'd4);
`ifndef TILE_WRITER_VBLANK_ONLY_EN
        @(negedge clk);
        check("write_latency_we", 32'(we), 1);
        check("write_latency_addr", 32'(waddr), 101);
        check("write_latency_data", 32'(wdata), 4);
        check("write_busy", 32'(busy), 1);
        @(negedge clk);
        check("write_single_pulse", 32'(we), 0);
        check("write_hold_addr", 32'(waddr), 101);
`endif
        wait_idle();

        // Out-of-bounds row
        do_req(5'd7, 5'd24, 8'd9);
        @(negedge clk);
        check("oob_err_pulse", 32'(err_oob), 1);
        check("oob_no_write", 32'(we), 0);
        check("oob_ready", 32'(req_ready), 1);
        @(negedge clk);
        check("oob_err_once", 32'(err_oob), 0);

`ifdef TILE_WRITER_VBLANK_ONLY_EN
        wait_idle();
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (vblank) found = 1'b1;
        end
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (!vblank) found = 1'b1;
        end
        check("vblank_fall_seen", 32'(found), 1);
        do_req(5'd31, 5'd23, 8'd7);
        @(negedge clk);
        check("vb_hold_we", 32'(we), 0);
        check("vb_hold_busy", 32'(busy), 1);
        check("vb_hold_ready", 32'(req_ready), 0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (we) found = 1'b1;
        end
        check("vb_write_issued", 32'(found), 1);
`endif

        // Randomized single-tile traffic, including some illegal rows
        for (int n = 0; n < 40; n++) begin
            do_req(5'($urandom_range(0, 31)), 5'($urandom_range(0, 27)), CODE_W'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        do_clear(8'd2, 1'b1);
        do_clear(CODE_W'($urandom_range(0, 7)), 1'b1);

        // Reset in the middle of a sweep abandons it
        do_clear(8'd5, 1'b0);
        found = 1'b0;
        for (int i = 0; i < TMO_CLEAR && !found; i++) begin
            @(negedge clk);
            if (we && waddr == 10'd300) found = 1'b1;
        end
        check("sweep_reached_300", 32'(found), 1);
        #1 reset = 1'b0;
        #1 check_all_zero("midsweep_reset");
        exp_wr.delete();
        n_exp_done = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("ready_after_midsweep", 32'(req_ready), 1);
        repeat (100) @(negedge clk);
        check("no_resume_busy", 32'(busy), 0);

        for (int n = 0; n < 10; n++) begin
            do_req(5'($urandom_range(0, 31)), 5'($urandom_range(0, 25)), CODE_W'($urandom_range(0, 7)));
        end

        wait_idle();
        repeat (5) @(negedge clk);
        check("writes_drained", 32'(exp_wr.size()), 0);
        check("errs_drained", 32'(n_exp_err), 0);
        check("dones_drained", 32'(n_exp_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_writer.md
TILE_WRITER -- requirements
Module: tile_writer

Interface
REQ-001 Parameter CODE_W, default 8, tile code width in bits.
REQ-002 Parameter ADDR_W, default 10, tile RAM address width in bits.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  game logic offers a single-tile write.
REQ-006 req_ready  output  1  block accepts the offered write this cycle.
REQ-007 req_x  input  5  tile column, 0..31.
REQ-008 req_y  input  5  tile row, 0..23 legal.
REQ-009 req_code  input  CODE_W  tile code: 0 black, 1 blue, 2 green, 3 cyan, 4 red, 5 purple, 6 yellow, 7 white.
REQ-010 clear_start  input  1  one-cycle pulse requesting a full-grid fill.
REQ-011 clear_code  input  CODE_W  fill code; sampled on clear_start.
REQ-012 vblank  input  1  display in vertical blanking; used only under REQ-030.
REQ-013 we  output  1  tile RAM write enable.
REQ-014 waddr  output  ADDR_W  tile RAM address, y*32+x.
REQ-015 wdata  output  CODE_W  tile RAM write data.
REQ-016 busy  output  1  high while a write is pending or a clear is running.
REQ-017 clear_done  output  1  one-cycle pulse when a clear completes.
REQ-018 err_oob  output  1  one-cycle pulse when an accepted request has req_y>23.

Function
REQ-019 States: IDLE, WRITE, CLEAR; handshake when req_valid & req_ready.
REQ-020 req_ready = (state==IDLE) & ~clear_start, combinationally.
REQ-021 Handshake with req_y<=23: next cycle state=WRITE, we=1, waddr={req_y,req_x}, wdata=req_code; state returns to IDLE the following cycle (1-cycle latency, 1 write per request).
REQ-022 Handshake with req_y>23: no write, err_oob=1 next cycle, state stays IDLE.
REQ-023 clear_start in IDLE: latch clear_code, enter CLEAR; same-cycle req_valid is not accepted.
REQ-024 CLEAR: one write per cycle, waddr 0,1,...,767, wdata=latched code; after address 767 is written, clear_done=1 for one cycle and state=IDLE; 768 writes total.
REQ-025 clear_start outside IDLE is ignored; no queueing.
REQ-026 we=0 whenever no write occurs this cycle; waddr/wdata hold last values when we=0.
REQ-027 busy = (state!=IDLE).

Reset
REQ-028 reset low at any time, including mid-CLEAR or mid-WRITE: state=IDLE, sweep counter=0, we=0, waddr=0, wdata=0, clear_done=0, err_oob=0, busy=0; an interrupted clear is abandoned and not resumed.
REQ-029 After reset deasserts, req_ready=1 in the first cycle (absent clear_start).

Configuration
REQ-030 Macro TILE_WRITER_VBLANK_ONLY_EN defined: writes issue only in cycles with vblank=1; a pending WRITE holds (we=0, busy=1, req_ready=0) until vblank=1; CLEAR pauses its address counter while vblank=0 and resumes at the same address.
REQ-031 Macro undefined: vblank is ignored and REQ-021/REQ-024 timing is exact.

Structure
REQ-032 Package vga_tile_pkg holds TILES_X=32, TILES_Y=24, TILE_PX=20, NUM_TILES=768, the tile-code enum (black..white, values 0..7), and the writer state enum.
REQ-033 Sub-module tile_sweep_counter: 10-bit counter with clear, enable, and terminal-count (767) flag; used for CLEAR.

Verification
REQ-034 Reset mid-sweep: reset low at clear address 300 -> all outputs 0 immediately; after release, req_ready=1 and no further clear writes.
REQ-035 Request x=5, y=3, code=4, macro off -> exactly one we pulse, waddr=101, wdata=4, one cycle after handshake.
REQ-036 Request y=24 -> no we, err_oob pulses once, req_ready returns to 1.
REQ-037 clear_start with code 2 plus simultaneous req_valid -> request not accepted; 768 consecutive writes 0..767 with data 2; clear_done on the cycle after address 767.
REQ-038 Macro on, vblank=0, request x=31, y=23, code=7 -> we stays 0 and busy=1; on vblank rising, one write waddr=767, wdata=7.
REQ-039 Macro on, clear with vblank toggling 100 cycles high/100 low -> addresses strictly sequential with no gaps or repeats; we only while vblank=1; exactly 768 writes.
